input_conditioner: RTL
======================

// Module: input_conditioner
// PURPOSE
//   Receive side of the board I/O: synchronises, debounces and edge-detects raw
//   switch/sensor pins (sw0=SnsA, sw2=E, sw7=SW7). Produces clean levels, 1-cycle
//   edge strobes, T-FF toggle levels, and an over-current fault flag.
//   Sits between the board pins and the 7-segment/motor logic, which consume only
//   conditioned signals.
// PARAMETERS
//   N_CH       3       number of input channels (bit 0 = SnsA, 1 = E, 2 = SW7)
//   DB_CYCLES  100000  stable-cycles required to accept a change (1 ms @ 100 MHz); >= 2
//   CNT_W      17      debounce counter width; 2**CNT_W > DB_CYCLES
// PORTS
//   CLK        in   1     system clock, all logic on posedge
//   RST        in   1     synchronous, active-high reset
//   raw_in     in   N_CH  asynchronous pin inputs
//   clr_fault  in   1     clear sticky fault (used only with FAULT_LATCH_EN)
//   level      out  N_CH  debounced level
//   rise       out  N_CH  1-cycle strobe on debounced 0->1
//   fall       out  N_CH  1-cycle strobe on debounced 1->0
//   toggle     out  N_CH  flips on each rise (T-FF per channel)
//   fault      out  1     over-current indication from channel 0
// BEHAVIOUR
//   - Reset: sync regs, counters, level, rise, fall, toggle and fault all 0.
//     No strobes in the cycle after RST deasserts when raw_in is low.
//   - Synchroniser: 2 flops per channel (s1 <= raw_in, s2 <= s1). Nothing else
//     samples raw_in.
//   - Debounce per channel:
//       s2 == level                      -> cnt <= 0
//       s2 != level, cnt <  DB_CYCLES-1  -> cnt <= cnt+1
//       s2 != level, cnt == DB_CYCLES-1  -> level <= s2, cnt <= 0, strobe
//   - Any bounce back to level before terminal count restarts the count from 0.
//   - Latency: a clean step on raw_in updates level on the (DB_CYCLES+2)th posedge.
//   - rise/fall are registered. Each is high exactly the cycle level changes,
//     never both, never two cycles in a row.
//   - toggle[i] <= ~toggle[i] on the same edge rise[i] asserts. Unaffected by fall.
//   - Channels are fully independent. Simultaneous changes on several channels all
//     complete in the same cycle.
//   - RST mid-count discards the count and level. A pin held high through reset
//     is re-accepted DB_CYCLES+2 cycles after release and produces a rise.
//   - Counter never exceeds DB_CYCLES-1; no wrap.
// CONFIGURATION
//   FAULT_LATCH_EN defined:
//     fault is sticky. It sets on rise[0] and clears on clr_fault.
//     Set and clear in the same cycle: set wins.
//     Reset clears it.
//   FAULT_LATCH_EN undefined:
//     fault == level[0] (a wire copy). clr_fault is ignored.
// STRUCTURE
//   input_cond_pkg:
//     CH_SNSA=0, CH_E=1, CH_SW7=2
//     DB_CYCLES_DEFAULT=100000
//     DB_CYCLES_SIM=4
//   Sub-module debounce_ch:
//     one channel (sync + counter + level + rise/fall + toggle).
//     Instantiated N_CH times with generate.
//   Fault logic lives in the top module.
// TESTING  (DB_CYCLES=4 unless noted)
//   1 Reset: hold RST 3 cycles with raw_in=3'b111 -> all outputs 0 during reset.
//     Release -> level=111 at posedge 6 after release, with one rise pulse per
//     channel and toggle=111.
//   2 Clean step: raw_in[2] 0->1 at cycle 0 -> level[2]=1 and rise[2]=1 at
//     cycle 6 only. fall stays 0. toggle[2] flips once.
//   3 Bounce: raw_in[1] high 3 cycles, low 1, high steady -> no strobe from the
//     first burst. level[1] rises 6 cycles after the final edge.
//   4 Release: after test 2, raw_in[2] 1->0 -> fall[2] pulses at cycle 6.
//     toggle[2] unchanged.
//   5 Fault (FAULT_LATCH_EN): pulse raw_in[0] high 10 cycles then low -> fault=1
//     and stays 1. clr_fault asserted alone -> fault=0 next cycle. clr_fault
//     asserted in the rise[0] cycle -> fault=1.
//     Without the macro -> fault tracks level[0].
//   6 Mid-count reset: raw_in[0] high, RST asserted at count 2 -> level[0] stays
//     0. After release, level[0]=1 exactly 6 cycles later.

Source files
------------

// File: rtl/input_cond_pkg.sv
// Shared constants for the board input conditioner: channel indices and
// debounce timing defaults for silicon and for short simulations.
package input_cond_pkg;

  // Channel assignment on the raw pin bus
  localparam int CH_SNSA = 0;
  localparam int CH_E    = 1;
  localparam int CH_SW7  = 2;

  // 1 ms at 100 MHz on hardware, a handful of cycles in simulation
  localparam int DB_CYCLES_DEFAULT = 100000;
  localparam int DB_CYCLES_SIM     = 4;
  localparam int CNT_W_DEFAULT     = 17;

endpackage : input_cond_pkg

// File: rtl/debounce_ch.sv
// One conditioned input channel: two-flop synchroniser, stability counter,
// debounced level, registered rise/fall strobes and a T-FF on each rise.
module debounce_ch
  import input_cond_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle
);

  // Terminal count: DB_CYCLES consecutive disagreeing samples accept the change
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s1_r;
  logic             s2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             level_r;
  logic             rise_r;
  logic             fall_r;
  logic             toggle_r;
  logic             differ_s;
  logic             terminal_s;

  assign differ_s   = (s2_r != level_r);
  assign terminal_s = (cnt_r == CNT_TERM);

  // Bring the asynchronous pin into the clock domain
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= raw_in;
      s2_r <= s1_r;
    end
  end

  // Count consecutive disagreeing samples; accept the new level at terminal count
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r    <= CNT_ZERO;
      level_r  <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
      toggle_r <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      if (!differ_s) begin
        // Any return to the current level restarts the qualification
        cnt_r <= CNT_ZERO;
      end else if (!terminal_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r    <= CNT_ZERO;
        level_r  <= s2_r;
        rise_r   <= s2_r;
        fall_r   <= ~s2_r;
        toggle_r <= toggle_r ^ s2_r;
      end
    end
  end

  assign level  = level_r;
  assign rise   = rise_r;
  assign fall   = fall_r;
  assign toggle = toggle_r;

endmodule : debounce_ch

// File: rtl/input_conditioner.sv
// Receive side of the board I/O: conditions the raw switch/sensor pins into
// clean levels, edge strobes and toggle levels, and derives the over-current
// fault from the SnsA channel.
// Build option: define FAULT_LATCH_EN for a sticky fault cleared by clr_fault;
// otherwise fault is a plain copy of the debounced SnsA level.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] raw_in,
  input  logic            clr_fault,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] toggle,
  output logic            fault
);

  // Independent conditioning path per pin
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_ch (
      .CLK    (CLK),
      .RST    (RST),
      .raw_in (raw_in[gi]),
      .level  (level[gi]),
      .rise   (rise[gi]),
      .fall   (fall[gi]),
      .toggle (toggle[gi])
    );
  end

`ifdef FAULT_LATCH_EN
  logic fault_r;

  // Sticky fault: set by a SnsA rise strobe, which wins over a simultaneous clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      fault_r <= 1'b0;
    end else if (rise[CH_SNSA]) begin
      fault_r <= 1'b1;
    end else if (clr_fault) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= fault_r;
    end
  end

  assign fault = fault_r;
`else
  logic unused_clr_s;

  // Without latching, the fault simply follows the debounced SnsA level
  assign fault        = level[CH_SNSA];
  assign unused_clr_s = clr_fault;
`endif

endmodule : input_conditioner
